// File: rtl/cursor_stepper_pkg.sv
// Shared types for the cursor stepper: repeat FSM states, direction bit indices
// and the per-axis request encoding.
package cursor_stepper_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  localparam int DIR_RIGHT = 3;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_UP    = 0;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_INC  = 2'd1,
    REQ_DEC  = 2'd2
  } req_t;

  // Opposing buttons held together cancel to no request.
  function automatic req_t decode_req(input logic inc, input logic dec);
    if (inc && !dec) return REQ_INC;
    if (dec && !inc) return REQ_DEC;
    return REQ_NONE;
  endfunction

endpackage

// File: rtl/cursor_stepper_axis_repeat.sv
// Per-axis press detector with optional hold-to-repeat (CURSOR_AUTOREPEAT_EN).
// Step pulses are combinational so the coordinate moves on the sampling edge.
//
//   state  | meaning
//   IDLE   | no request held, or movement disabled
//   DELAY  | stepped on press, waiting REPEAT_DELAY cycles for first repeat
//   REPEAT | auto-repeating every REPEAT_RATE cycles
module axis_repeat
  import cursor_stepper_pkg::*;
#(
  parameter int REPEAT_DELAY = 24,
  parameter int REPEAT_RATE  = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic inc,
  input  logic dec,
  output logic step_inc,
  output logic step_dec
);

  if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("axis_repeat: REPEAT_DELAY and REPEAT_RATE must be >= 1");
  end

  req_t req;
  req_t prev_q;
  logic fire;

  assign req = decode_req(inc, dec);

`ifdef CURSOR_AUTOREPEAT_EN
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  rpt_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prev_q  <= REQ_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= req;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!en || req == REQ_NONE) begin
      state_d = IDLE;
    end else if (req != prev_q) begin
      state_d = DELAY;
      cnt_d   = CNT_W'(REPEAT_DELAY - 1);
    end else if (state_q != IDLE) begin
      if (cnt_q == '0) begin
        state_d = REPEAT;
        cnt_d   = CNT_W'(REPEAT_RATE - 1);
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_comb begin
    fire = 1'b0;
    if (en && req != REQ_NONE)
      fire = (req != prev_q) || (state_q != IDLE && cnt_q == '0);
  end
`else
  // Edge-only build: no counters, a step happens only when the request changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= REQ_NONE;
    else     prev_q <= req;
  end

  always_comb begin
    fire = en && (req != REQ_NONE) && (req != prev_q);
  end
`endif

  assign step_inc = fire && (req == REQ_INC);
  assign step_dec = fire && (req == REQ_DEC);

endmodule

// File: rtl/cursor_stepper.sv
// X,Y cursor on a configurable grid with wrap/clamp, load and event pulses.
// Hold-to-repeat is present only when CURSOR_AUTOREPEAT_EN is defined.
module cursor_stepper
  import cursor_stepper_pkg::*;
#(
  parameter int COORD_W      = 8,
  parameter int X_MAX        = 255,
  parameter int Y_MAX        = 255,
  parameter int REPEAT_DELAY = 24,
  parameter int REPEAT_RATE  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         dir_udlr,
  input  logic               en,
  input  logic               wrap_en,
  input  logic               load,
  input  logic [COORD_W-1:0] load_x,
  input  logic [COORD_W-1:0] load_y,
  output logic [COORD_W-1:0] x_pos,
  output logic [COORD_W-1:0] y_pos,
  output logic               moved,
  output logic               edge_hit
);

  localparam logic [COORD_W-1:0] XM = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] YM = COORD_W'(Y_MAX);

  logic x_inc, x_dec, y_inc, y_dec;
  logic [COORD_W-1:0] x_d, y_d;
  logic x_edge, y_edge;
  logic moved_d, edge_d;

  axis_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_axis_x (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .inc      (dir_udlr[DIR_RIGHT]),
    .dec      (dir_udlr[DIR_LEFT]),
    .step_inc (x_inc),
    .step_dec (x_dec)
  );

  axis_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_axis_y (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .inc      (dir_udlr[DIR_UP]),
    .dec      (dir_udlr[DIR_DOWN]),
    .step_inc (y_inc),
    .step_dec (y_dec)
  );

  // Boundary steps wrap to the grid limit, not the coordinate width.
  always_comb begin
    x_d    = x_pos;
    x_edge = 1'b0;
    if (x_inc) begin
      if (x_pos == XM) begin
        x_edge = 1'b1;
        if (wrap_en) x_d = '0;
      end else begin
        x_d = x_pos + 1'b1;
      end
    end else if (x_dec) begin
      if (x_pos == '0) begin
        x_edge = 1'b1;
        if (wrap_en) x_d = XM;
      end else begin
        x_d = x_pos - 1'b1;
      end
    end
  end

  always_comb begin
    y_d    = y_pos;
    y_edge = 1'b0;
    if (y_inc) begin
      if (y_pos == YM) begin
        y_edge = 1'b1;
        if (wrap_en) y_d = '0;
      end else begin
        y_d = y_pos + 1'b1;
      end
    end else if (y_dec) begin
      if (y_pos == '0) begin
        y_edge = 1'b1;
        if (wrap_en) y_d = YM;
      end else begin
        y_d = y_pos - 1'b1;
      end
    end
  end

  assign moved_d = (x_d != x_pos) || (y_d != y_pos);
  assign edge_d  = x_edge || y_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_pos    <= '0;
      y_pos    <= '0;
      moved    <= 1'b0;
      edge_hit <= 1'b0;
    end else if (load) begin
      x_pos    <= (load_x > XM) ? XM : load_x;
      y_pos    <= (load_y > YM) ? YM : load_y;
      moved    <= 1'b0;
      edge_hit <= 1'b0;
    end else begin
      x_pos    <= x_d;
      y_pos    <= y_d;
      moved    <= moved_d;
      edge_hit <= edge_d;
    end
  end

endmodule
